gshare_pred: RTL

GSHARE_PRED -- requirements
Module: gshare_pred

---
 rtl/gshare_pred.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/gshare_pred.sv
// Gshare branch predictor: per-slot PHT lookup hashed with global history, set-associative
// BTB with true-LRU ages, one-cycle registered prediction and in-order retire updates.
module gshare_pred #(
    parameter int FETCH_WIDTH = 4,
    parameter int UPD_WIDTH   = 2,
    parameter int GHR_LEN     = 8,
    parameter int BTB_SETS    = 64,
    parameter int BTB_WAYS    = 4
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              fetch_valid,
    input  logic [31:0]                       fetch_pc,
    input  logic [FETCH_WIDTH-1:0]            fetch_is_branch,
    output logic                              pred_valid,
    output logic [FETCH_WIDTH-1:0]            pred_taken,
    output logic [31:0]                       pred_target,
    output logic [GHR_LEN-1:0]                pred_ghr,
    input  logic [UPD_WIDTH-1:0]              upd_valid,
    input  logic [UPD_WIDTH-1:0]              upd_taken,
    input  logic [UPD_WIDTH-1:0]              upd_mispredict,
    input  logic [UPD_WIDTH-1:0][31:0]        upd_pc,
    input  logic [UPD_WIDTH-1:0][31:0]        upd_target,
    input  logic [UPD_WIDTH-1:0][GHR_LEN-1:0] upd_ghr
);

    localparam int PHT_SIZE    = 1 << GHR_LEN;
    localparam int SET_BITS    = $clog2(BTB_SETS);
    localparam int TAG_W       = 30 - SET_BITS;
    localparam int AGE_W       = (BTB_WAYS > 1) ? $clog2(BTB_WAYS) : 1;
    localparam int FETCH_BYTES = 4 * FETCH_WIDTH;

    genvar gi;

    logic [GHR_LEN-1:0] ghr_reg, ghr_next;
    logic [1:0]         pht_reg  [PHT_SIZE];
    logic [1:0]         pht_next [PHT_SIZE];

    logic               btb_valid_reg  [BTB_SETS][BTB_WAYS];
    logic               btb_valid_next [BTB_SETS][BTB_WAYS];
    logic [TAG_W-1:0]   btb_tag_reg    [BTB_SETS][BTB_WAYS];
    logic [TAG_W-1:0]   btb_tag_next   [BTB_SETS][BTB_WAYS];
    logic [31:0]        btb_target_reg [BTB_SETS][BTB_WAYS];
    logic [31:0]        btb_target_next[BTB_SETS][BTB_WAYS];
    logic [AGE_W-1:0]   btb_age_reg    [BTB_SETS][BTB_WAYS];
    logic [AGE_W-1:0]   btb_age_next   [BTB_SETS][BTB_WAYS];

    logic                   pred_valid_reg, pred_valid_next;
    logic [FETCH_WIDTH-1:0] pred_taken_reg;
    logic [31:0]            pred_target_reg;
    logic [GHR_LEN-1:0]     pred_ghr_reg;

    logic [FETCH_WIDTH-1:0] slot_taken;
    logic [31:0]            slot_target [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0] first_taken;
    logic                   any_taken;
    logic [31:0]            sel_target;
    logic                   recover_found;

    assign pred_valid  = pred_valid_reg;
    assign pred_taken  = pred_taken_reg;
    assign pred_target = pred_target_reg;
    assign pred_ghr    = pred_ghr_reg;

    // Fetch-side lookup: every slot reads the state as it stood at the start of the cycle.
    generate
        for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_slot
            logic [31:0]         slot_pc;
            logic [GHR_LEN-1:0]  slot_idx;
            logic [SET_BITS-1:0] slot_set;
            logic [TAG_W-1:0]    slot_tag;
            logic                slot_hit;
            logic [31:0]         slot_tgt;
            logic [1:0]          unused_slot_lsbs;

            assign slot_pc          = fetch_pc + 32'(4 * gi);
            assign slot_idx         = slot_pc[GHR_LEN+1:2] ^ ghr_reg;
            assign slot_set         = slot_pc[SET_BITS+1:2];
            assign slot_tag         = slot_pc[31:SET_BITS+2];
            assign unused_slot_lsbs = slot_pc[1:0];

            always_comb begin
                slot_hit = 1'b0;
                slot_tgt = '0;
                for (int w = 0; w < BTB_WAYS; w++) begin
                    if (btb_valid_reg[slot_set][w] && (btb_tag_reg[slot_set][w] == slot_tag)) begin
                        slot_hit = 1'b1;
                        slot_tgt = btb_target_reg[slot_set][w];
                    end
                end
            end

            assign slot_taken[gi]  = fetch_is_branch[gi] & pht_reg[slot_idx][1] & slot_hit;
            assign slot_target[gi] = slot_tgt;
        end
    endgenerate

    always_comb begin
        first_taken = slot_taken & (~slot_taken + FETCH_WIDTH'(1));
        any_taken   = |slot_taken;
        sel_target  = fetch_pc + 32'(FETCH_BYTES);
        for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
            if (slot_taken[i]) begin
                sel_target = slot_target[i];
            end
        end
    end

    // Oldest mispredicting retire port restores history and squashes the in-flight prediction.
    always_comb begin
        ghr_next      = ghr_reg;
        recover_found = 1'b0;
        if (fetch_valid && (|fetch_is_branch)) begin
            ghr_next = {ghr_reg[GHR_LEN-2:0], any_taken};
        end
        for (int p = 0; p < UPD_WIDTH; p++) begin
            if (!recover_found && upd_valid[p] && upd_mispredict[p]) begin
                recover_found = 1'b1;
                ghr_next      = {upd_ghr[p][GHR_LEN-2:0], upd_taken[p]};
            end
        end
        pred_valid_next = fetch_valid & ~recover_found;
    end

    logic [GHR_LEN-1:0]  upd_pht_idx [UPD_WIDTH];
    logic [SET_BITS-1:0] upd_set     [UPD_WIDTH];
    logic [TAG_W-1:0]    upd_tag     [UPD_WIDTH];
    logic [2*UPD_WIDTH-1:0] unused_upd_lsbs;

    generate
        for (gi = 0; gi < UPD_WIDTH; gi++) begin : g_upd
            assign upd_pht_idx[gi]           = upd_pc[gi][GHR_LEN+1:2] ^ upd_ghr[gi];
            assign upd_set[gi]               = upd_pc[gi][SET_BITS+1:2];
            assign upd_tag[gi]               = upd_pc[gi][31:SET_BITS+2];
            assign unused_upd_lsbs[2*gi +: 2] = upd_pc[gi][1:0];
        end
    endgenerate

    // Ports are applied in order on a working copy so same-entry updates accumulate.
    always_comb begin
        pht_next = pht_reg;
        for (int p = 0; p < UPD_WIDTH; p++) begin
            if (upd_valid[p]) begin
                if (upd_taken[p]) begin
                    if (pht_next[upd_pht_idx[p]] != 2'b11) begin
                        pht_next[upd_pht_idx[p]] = pht_next[upd_pht_idx[p]] + 2'b01;
                    end
                end else if (pht_next[upd_pht_idx[p]] != 2'b00) begin
                    pht_next[upd_pht_idx[p]] = pht_next[upd_pht_idx[p]] - 2'b01;
                end
            end
        end
    end

    logic [SET_BITS-1:0] bu_set;
    logic                bu_hit;
    logic                bu_inv_found;
    logic [AGE_W-1:0]    bu_hit_way;
    logic [AGE_W-1:0]    bu_inv_way;
    logic [AGE_W-1:0]    bu_lru_way;
    logic [AGE_W-1:0]    bu_way;
    logic [AGE_W-1:0]    bu_old_age;

    // Age 0 is MRU, age BTB_WAYS-1 is LRU; touching a way ages every younger way by one.
    always_comb begin
        btb_valid_next  = btb_valid_reg;
        btb_tag_next    = btb_tag_reg;
        btb_target_next = btb_target_reg;
        btb_age_next    = btb_age_reg;
        bu_set          = '0;
        bu_hit          = 1'b0;
        bu_inv_found    = 1'b0;
        bu_hit_way      = '0;
        bu_inv_way      = '0;
        bu_lru_way      = '0;
        bu_way          = '0;
        bu_old_age      = '0;
        for (int p = 0; p < UPD_WIDTH; p++) begin
            if (upd_valid[p] && upd_taken[p]) begin
                bu_set       = upd_set[p];
                bu_hit       = 1'b0;
                bu_inv_found = 1'b0;
                bu_hit_way   = '0;
                bu_inv_way   = '0;
                bu_lru_way   = '0;
                for (int w = BTB_WAYS - 1; w >= 0; w--) begin
                    if (btb_valid_next[bu_set][w] && (btb_tag_next[bu_set][w] == upd_tag[p])) begin
                        bu_hit     = 1'b1;
                        bu_hit_way = AGE_W'(w);
                    end
                    if (!btb_valid_next[bu_set][w]) begin
                        bu_inv_found = 1'b1;
                        bu_inv_way   = AGE_W'(w);
                    end
                    if (btb_age_next[bu_set][w] == AGE_W'(BTB_WAYS - 1)) begin
                        bu_lru_way = AGE_W'(w);
                    end
                end
                bu_way = bu_hit ? bu_hit_way : (bu_inv_found ? bu_inv_way : bu_lru_way);
                btb_valid_next[bu_set][bu_way]  = 1'b1;
                btb_tag_next[bu_set][bu_way]    = upd_tag[p];
                btb_target_next[bu_set][bu_way] = upd_target[p];
                bu_old_age = btb_age_next[bu_set][bu_way];
                for (int w = 0; w < BTB_WAYS; w++) begin
                    if (btb_age_next[bu_set][w] < bu_old_age) begin
                        btb_age_next[bu_set][w] = btb_age_next[bu_set][w] + AGE_W'(1);
                    end
                end
                btb_age_next[bu_set][bu_way] = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pred_valid_reg  <= 1'b0;
            pred_taken_reg  <= '0;
            pred_target_reg <= '0;
            pred_ghr_reg    <= '0;
            ghr_reg         <= '0;
            for (int i = 0; i < PHT_SIZE; i++) begin
                pht_reg[i] <= 2'b01;
            end
            for (int s = 0; s < BTB_SETS; s++) begin
                for (int w = 0; w < BTB_WAYS; w++) begin
                    btb_valid_reg[s][w] <= 1'b0;
                    btb_age_reg[s][w]   <= AGE_W'(w);
                end
            end
        end else begin
            pred_valid_reg  <= pred_valid_next;
            pred_taken_reg  <= pred_valid_next ? first_taken : '0;
            pred_target_reg <= sel_target;
            pred_ghr_reg    <= ghr_reg;
            ghr_reg         <= ghr_next;
            pht_reg         <= pht_next;
            btb_valid_reg   <= btb_valid_next;
            btb_age_reg     <= btb_age_next;
        end
    end

    // Tag and target payload is qualified by valid, so it needs no reset.
    always_ff @(posedge clock) begin
        btb_tag_reg    <= btb_tag_next;
        btb_target_reg <= btb_target_next;
    end

endmodule
